crank_wheel_sim: RTL and testbench

Generates a synthetic missing-tooth crank trigger-wheel signal from a programmable tooth period, for closed-loop bench and self-test of the RPM input path. It is the transmitting end of the tooth-period measurement chain: the RPM input stages turn tooth edges into a moving sum of periods, and this block turns a commanded period back into tooth edges. It sits in the test/stimulus area and can drive the crank input mux in place of the physical sensor.

---
 rtl/crank_wheel_sim.sv | 103 ++++++++++
 tb/tb_crank_wheel_sim.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/crank_wheel_sim.sv
// Synthetic missing-tooth crank wheel: turns a commanded tooth period into tooth edges
// plus a once-per-revolution sync pulse for closed-loop test of the RPM input path.
module crank_wheel_sim #(
    parameter int unsigned PERIOD_WIDTH = 16,
    parameter int unsigned TEETH        = 36,
    parameter int unsigned MISSING      = 1,
    parameter int unsigned IDX_WIDTH    = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    load,
    input  logic [PERIOD_WIDTH-1:0] period_in,
    output logic                    tooth_out,
    output logic                    sync_out,
    output logic [IDX_WIDTH-1:0]    tooth_idx,
    output logic [PERIOD_WIDTH-1:0] period_active
);

    localparam logic [IDX_WIDTH-1:0]    LAST_IDX      = IDX_WIDTH'(TEETH - 1);
    localparam logic [IDX_WIDTH-1:0]    FIRST_MISSING = IDX_WIDTH'(TEETH - MISSING);
    localparam logic [PERIOD_WIDTH-1:0] MIN_PERIOD    = PERIOD_WIDTH'(2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_n;
    logic [PERIOD_WIDTH-1:0] pend, pend_n;
    logic                    pend_valid, pend_valid_n;
    logic [PERIOD_WIDTH-1:0] ph, ph_n;
    logic [PERIOD_WIDTH-1:0] act_n;
    logic [PERIOD_WIDTH-1:0] load_val;
    logic [IDX_WIDTH-1:0]    t_n;
    logic                    tooth_n, sync_n;

    // Next-state counters; outputs are decoded from the next values so they register in step.
    always_comb begin
        load_val     = (period_in < MIN_PERIOD) ? MIN_PERIOD : period_in;
        state_n      = state;
        pend_n       = pend;
        pend_valid_n = pend_valid;
        act_n        = period_active;
        ph_n         = '0;
        t_n          = '0;
        tooth_n      = 1'b0;
        sync_n       = 1'b0;

        if (load) begin
            pend_n       = load_val;
            pend_valid_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (en && (pend_valid || load)) begin
                    state_n = RUN;
                    act_n   = load ? load_val : pend;
                end
            end
            RUN: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (ph == period_active - PERIOD_WIDTH'(1)) begin
                    // A load on the boundary cycle bypasses pend into the new tooth.
                    t_n   = (tooth_idx == LAST_IDX) ? '0 : tooth_idx + IDX_WIDTH'(1);
                    act_n = load ? load_val : pend;
                end else begin
                    ph_n = ph + PERIOD_WIDTH'(1);
                    t_n  = tooth_idx;
                end
            end
            default: state_n = IDLE;
        endcase

        if (state_n == RUN) begin
            tooth_n = (ph_n < (act_n >> 1)) && (t_n < FIRST_MISSING);
            sync_n  = (ph_n == '0) && (t_n == '0);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pend          <= '0;
            pend_valid    <= 1'b0;
            ph            <= '0;
            period_active <= '0;
            tooth_idx     <= '0;
            tooth_out     <= 1'b0;
            sync_out      <= 1'b0;
        end else begin
            state         <= state_n;
            pend          <= pend_n;
            pend_valid    <= pend_valid_n;
            ph            <= ph_n;
            period_active <= act_n;
            tooth_idx     <= t_n;
            tooth_out     <= tooth_n;
            sync_out      <= sync_n;
        end
    end

endmodule

// File: tb/tb_crank_wheel_sim.sv
// Bench for crank_wheel_sim: directed scenarios plus random traffic against an
// elapsed-time reference model of the trigger wheel.
module tb_crank_wheel_sim;

    localparam int unsigned PW      = 16;
    localparam int unsigned TEETH   = 4;
    localparam int unsigned MISSING = 1;
    localparam int unsigned IW      = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          load;
    logic [PW-1:0] period_in;
    logic          tooth_out;
    logic          sync_out;
    logic [IW-1:0] tooth_idx;
    logic [PW-1:0] period_active;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: wheel position tracked as time elapsed since the tooth began.
    bit m_run;
    int m_elapsed;
    int m_p;
    int m_idx;
    int m_pend;
    bit m_pv;

    crank_wheel_sim #(
        .PERIOD_WIDTH(PW),
        .TEETH       (TEETH),
        .MISSING     (MISSING),
        .IDX_WIDTH   (IW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .load         (load),
        .period_in    (period_in),
        .tooth_out    (tooth_out),
        .sync_out     (sync_out),
        .tooth_idx    (tooth_idx),
        .period_active(period_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_elapsed = 0; m_p = 0; m_idx = 0; m_pend = 0; m_pv = 0;
    endtask

    task automatic model_step();
        int lp;
        lp = (int'(period_in) < 2) ? 2 : int'(period_in);
        if (!m_run) begin
            if (en && (m_pv || load)) begin
                m_run = 1; m_elapsed = 0; m_idx = 0;
                m_p = load ? lp : m_pend;
            end
        end else if (!en) begin
            m_run = 0; m_elapsed = 0; m_idx = 0;
        end else begin
            m_elapsed++;
            if (m_elapsed == m_p) begin
                m_elapsed = 0;
                m_idx = (m_idx + 1) % TEETH;
                m_p = load ? lp : m_pend;
            end
        end
        if (load) begin
            m_pend = lp; m_pv = 1;
        end
    endtask

    task automatic check_outputs();
        bit exp_tooth, exp_sync;
        exp_tooth = m_run && (m_elapsed < m_p / 2) && (m_idx < int'(TEETH - MISSING));
        exp_sync  = m_run && (m_elapsed == 0) && (m_idx == 0);
        check("tooth_out", 32'(tooth_out), 32'(exp_tooth));
        check("sync_out", 32'(sync_out), 32'(exp_sync));
        check("tooth_idx", 32'(tooth_idx), 32'(m_run ? m_idx : 0));
        check("period_active", 32'(period_active), 32'(m_p));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic do_load(input int p);
        load = 1'b1;
        period_in = PW'(p);
        step();
        load = 1'b0;
    endtask

    initial begin
        int highs, syncs;
        bit found;

        reset = 1'b0; en = 1'b0; load = 1'b0; period_in = '0;
        model_reset();
        #12;
        check_outputs();
        #11 reset = 1'b1;

        // No load yet: enable alone must not start the wheel.
        en = 1'b1;
        repeat (5) step();
        do_load(8);
        check("start_sync", 32'(sync_out), 32'd1);
        check("start_tooth", 32'(tooth_out), 32'd1);
        repeat (40) step();

        // Basic revolution at P=10: 15 high cycles and one sync per 40 cycles.
        en = 1'b0;
        step();
        do_load(10);
        en = 1'b1;
        highs = 0; syncs = 0;
        repeat (80) begin
            step();
            highs += int'(tooth_out);
            syncs += int'(sync_out);
        end
        check("rev_highs", 32'(highs), 32'd30);
        check("rev_syncs", 32'(syncs), 32'd2);

        // Odd period, then clamp of 0 and 1.
        do_load(7);
        repeat (40) step();
        do_load(0);
        repeat (20) step();
        check("clamp0_pa", 32'(period_active), 32'd2);
        do_load(1);
        repeat (12) step();
        check("clamp1_pa", 32'(period_active), 32'd2);

        // Period change mid-tooth: load at ph=3 of tooth 1.
        en = 1'b0;
        step();
        do_load(10);
        en = 1'b1;
        for (int i = 0; i < 100 && !(m_run && m_idx == 1 && m_elapsed == 3); i++) step();
        found = m_run && m_idx == 1 && m_elapsed == 3;
        check("wait_t1_ph3", 32'(found), 32'd1);
        do_load(20);
        check("midload_pa", 32'(period_active), 32'd10);
        for (int i = 0; i < 100 && m_idx != 2; i++) step();
        check("chg_pa", 32'(period_active), 32'd20);
        repeat (50) step();

        // Load exactly on a boundary takes effect for the new tooth.
        for (int i = 0; i < 100 && !(m_run && m_elapsed == m_p - 1); i++) step();
        do_load(14);
        check("bnd_pa", 32'(period_active), 32'd14);
        check("bnd_ph0_tooth", 32'(tooth_out), 32'(m_idx < int'(TEETH - MISSING)));

        // Enable drop mid-high on tooth 2, then restart with the held period.
        for (int i = 0; i < 200 && !(m_idx == 2 && m_elapsed == 1); i++) step();
        en = 1'b0;
        step();
        check("drop_tooth", 32'(tooth_out), 32'd0);
        check("drop_idx", 32'(tooth_idx), 32'd0);
        en = 1'b1;
        step();
        check("restart_sync", 32'(sync_out), 32'd1);
        check("restart_pa", 32'(period_active), 32'd14);
        repeat (30) step();

        // Asynchronous reset between edges, then enable alone must not restart.
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #3 reset = 1'b1;
        repeat (6) step();
        check("post_rst_idle", 32'(tooth_out), 32'd0);
        do_load(12);
        check("post_rst_sync", 32'(sync_out), 32'd1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom % 60) != 0;
            load = ($urandom % 25) == 0;
            period_in = PW'($urandom_range(0, 13));
            step();
        end
        en = 1'b0; load = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
